// File: rtl/stitch_sb_pkg.sv
// Shared types and helpers for the scoreboard tag pool: tag type, prefix-rank
// popcount and modular pointer add.
package stitch_sb_pkg;

  localparam int unsigned SbNumTags = 8;
  localparam int unsigned SbTagW    = $clog2(SbNumTags);

  typedef logic [SbTagW-1:0] tag_t;

  // Number of set bits in vec strictly below bit position k.
  function automatic int unsigned prefix_rank(input logic [31:0] vec, input int unsigned k);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < k && vec[i]) r++;
    end
    return r;
  endfunction

  // Callers guarantee ptr < depth and inc <= depth, so one subtraction suffices.
  function automatic int unsigned ptr_add(input int unsigned ptr, input int unsigned inc,
                                          input int unsigned depth);
    int unsigned s;
    s = ptr + inc;
    return (s >= depth) ? s - depth : s;
  endfunction

endpackage

// File: rtl/stitch_sb_rank_enc.sv
// Prefix-popcount unit: per-bit rank (set bits below) and total set bits.
module stitch_sb_rank_enc
  import stitch_sb_pkg::*;
#(
  parameter  int unsigned N  = 2,
  localparam int unsigned RW = $clog2(N + 1)
) (
  input  logic [N-1:0]         vec_i,
  output logic [N-1:0][RW-1:0] rank_o,
  output logic [RW-1:0]        total_o
);

  always_comb begin
    rank_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      rank_o[k] = RW'(prefix_rank(32'(vec_i), k));
    end
    total_o = RW'(prefix_rank(32'(vec_i), N));
  end

endmodule

// File: rtl/stitch_sb_tag_pool.sv
// Multi-port circular free-list allocator for scoreboard tags.
// Optional double-free tracking enabled by STITCH_SB_TAG_POOL_CHECK_EN.
module stitch_sb_tag_pool
  import stitch_sb_pkg::*;
#(
  parameter  int unsigned NumTags  = 8,
  parameter  int unsigned NumAlloc = 2,
  parameter  int unsigned NumFree  = 2,
  localparam int unsigned TagW     = $clog2(NumTags),
  localparam int unsigned CntW     = $clog2(NumTags + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic [NumAlloc-1:0]            alloc_req_i,
  output logic [NumAlloc-1:0]            alloc_gnt_o,
  output logic [NumAlloc-1:0][TagW-1:0]  alloc_tag_o,
  input  logic [NumFree-1:0]             free_valid_i,
  input  logic [NumFree-1:0][TagW-1:0]   free_tag_i,
  output logic [CntW-1:0]                avail_o,
  output logic                           empty_o,
  output logic                           full_o,
  output logic                           err_o
);

  localparam int unsigned ARW = $clog2(NumAlloc + 1);
  localparam int unsigned FRW = $clog2(NumFree + 1);

  logic [TagW-1:0] mem_q [NumTags];
  logic [TagW-1:0] mem_d [NumTags];
  logic [TagW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            err_q, err_d;

  logic [NumAlloc-1:0][ARW-1:0] a_rank;
  logic [ARW-1:0]               a_req_cnt;
  logic [NumFree-1:0]           free_acc;
  logic [NumFree-1:0][FRW-1:0]  f_rank;
  logic [FRW-1:0]               f_cnt;
  int unsigned                  a_cnt;
  logic                         err_set;
  logic [TagW-1:0]              a_idx;

`ifdef STITCH_SB_TAG_POOL_CHECK_EN
  logic [NumTags-1:0] out_q, out_d, out_tmp;
  logic               dbl_free;
`endif

  stitch_sb_rank_enc #(.N(NumAlloc)) u_alloc_rank (
    .vec_i  (alloc_req_i),
    .rank_o (a_rank),
    .total_o(a_req_cnt)
  );

  stitch_sb_rank_enc #(.N(NumFree)) u_free_rank (
    .vec_i  (free_acc),
    .rank_o (f_rank),
    .total_o(f_cnt)
  );

  // Grant the lowest-ranked requesters while tags remain; ungranted tags read 0.
  always_comb begin
    alloc_gnt_o = '0;
    alloc_tag_o = '0;
    a_idx       = '0;
    for (int unsigned k = 0; k < NumAlloc; k++) begin
      if (alloc_req_i[k] && (32'(a_rank[k]) < 32'(count_q))) begin
        alloc_gnt_o[k] = 1'b1;
        a_idx          = TagW'(ptr_add(32'(rd_ptr_q), 32'(a_rank[k]), NumTags));
        alloc_tag_o[k] = mem_q[a_idx];
      end
    end
    a_cnt = (32'(a_req_cnt) < 32'(count_q)) ? 32'(a_req_cnt) : 32'(count_q);
  end

  // Frees are accepted in port order, so any dropped entry is the higher port.
  always_comb begin
    int unsigned nacc;
    free_acc = '0;
    err_set  = 1'b0;
    nacc     = 0;
`ifdef STITCH_SB_TAG_POOL_CHECK_EN
    out_tmp  = out_q;
    dbl_free = 1'b0;
`endif
    for (int unsigned j = 0; j < NumFree; j++) begin
      if (free_valid_i[j]) begin
        if (32'(free_tag_i[j]) >= NumTags) begin
          err_set = 1'b1;
`ifdef STITCH_SB_TAG_POOL_CHECK_EN
        end else if (!out_tmp[free_tag_i[j]]) begin
          err_set  = 1'b1;
          dbl_free = 1'b1;
`endif
        end else if (32'(count_q) + nacc >= NumTags) begin
          err_set = 1'b1;
        end else begin
          free_acc[j] = 1'b1;
          nacc++;
`ifdef STITCH_SB_TAG_POOL_CHECK_EN
          out_tmp[free_tag_i[j]] = 1'b0;
`endif
        end
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    for (int unsigned j = 0; j < NumFree; j++) begin
      if (free_acc[j]) begin
        mem_d[TagW'(ptr_add(32'(wr_ptr_q), 32'(f_rank[j]), NumTags))] = free_tag_i[j];
      end
    end
    rd_ptr_d = TagW'(ptr_add(32'(rd_ptr_q), a_cnt, NumTags));
    wr_ptr_d = TagW'(ptr_add(32'(wr_ptr_q), 32'(f_cnt), NumTags));
    count_d  = CntW'(32'(count_q) - a_cnt + 32'(f_cnt));
    err_d    = err_q | err_set;
`ifdef STITCH_SB_TAG_POOL_CHECK_EN
    out_d = out_tmp;
    for (int unsigned k = 0; k < NumAlloc; k++) begin
      if (alloc_gnt_o[k]) out_d[alloc_tag_o[k]] = 1'b1;
    end
`endif
    if (flush_i) begin
      for (int unsigned i = 0; i < NumTags; i++) mem_d[i] = TagW'(i);
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = CntW'(NumTags);
      err_d    = 1'b0;
`ifdef STITCH_SB_TAG_POOL_CHECK_EN
      out_d    = '0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumTags; i++) mem_q[i] <= TagW'(i);
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= CntW'(NumTags);
      err_q    <= 1'b0;
`ifdef STITCH_SB_TAG_POOL_CHECK_EN
      out_q    <= '0;
`endif
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
`ifdef STITCH_SB_TAG_POOL_CHECK_EN
      out_q    <= out_d;
`endif
    end
  end

  assign avail_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(NumTags));
  assign err_o   = err_q;

`ifdef STITCH_SB_TAG_POOL_CHECK_EN
`ifndef SYNTHESIS
  a_no_dbl_free: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i) !dbl_free);
`endif
`endif

endmodule

// File: tb/tb_stitch_sb_tag_pool.sv
// Directed bench for stitch_sb_tag_pool: an 8-tag instance and a 6-tag instance.
module tb_stitch_sb_tag_pool;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;

  logic            flush8, flush6;
  logic [1:0]      req8, gnt8, fv8, req6, gnt6, fv6;
  logic [1:0][2:0] tag8, ft8, tag6, ft6;
  logic [3:0]      avail8;
  logic [2:0]      avail6;
  logic            empty8, full8, err8, empty6, full6, err6;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  stitch_sb_tag_pool #(.NumTags(8), .NumAlloc(2), .NumFree(2)) u_dut8 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush8),
    .alloc_req_i(req8), .alloc_gnt_o(gnt8), .alloc_tag_o(tag8),
    .free_valid_i(fv8), .free_tag_i(ft8),
    .avail_o(avail8), .empty_o(empty8), .full_o(full8), .err_o(err8)
  );

  stitch_sb_tag_pool #(.NumTags(6), .NumAlloc(2), .NumFree(2)) u_dut6 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush6),
    .alloc_req_i(req6), .alloc_gnt_o(gnt6), .alloc_tag_o(tag6),
    .free_valid_i(fv6), .free_tag_i(ft6),
    .avail_o(avail6), .empty_o(empty6), .full_o(full6), .err_o(err6)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  int pool6[$];
  int outq[$];
`ifdef STITCH_SB_TAG_POOL_CHECK_EN
  localparam logic OvfErr = 1'b0;
`else
  localparam logic OvfErr = 1'b1;
`endif

  initial begin
    flush8 = 0; flush6 = 0; req8 = 0; req6 = 0; fv8 = 0; fv6 = 0; ft8 = '0; ft6 = '0;
    #12 rst_ni = 1'b1;
    tick();

    chk("rst_avail8", 32'(avail8), 8);
    chk("rst_full8", 32'(full8), 1);
    chk("rst_empty8", 32'(empty8), 0);
    chk("rst_err8", 32'(err8), 0);
    chk("rst_avail6", 32'(avail6), 6);

    req8 = 2'b11; #1;
    chk("first_gnt", 32'(gnt8), 3);
    chk("first_tag0", 32'(tag8[0]), 0);
    chk("first_tag1", 32'(tag8[1]), 1);
    tick();
    chk("after1_avail", 32'(avail8), 6);
    chk("after1_tag0", 32'(tag8[0]), 2);
    chk("after1_tag1", 32'(tag8[1]), 3);
    tick(); tick(); tick();
    chk("drain_avail", 32'(avail8), 0);
    chk("drain_empty", 32'(empty8), 1);
    chk("drain_gnt", 32'(gnt8), 0);
    chk("drain_tag0_zero", 32'(tag8[0]), 0);
    chk("drain_tag1_zero", 32'(tag8[1]), 0);

    // Free at empty: no bypass to the same-cycle grant.
    fv8 = 2'b01; ft8[0] = 3'd5; #1;
    chk("nobypass_gnt", 32'(gnt8), 0);
    tick();
    fv8 = 2'b00;
    chk("refill_avail", 32'(avail8), 1);
    chk("refill_gnt", 32'(gnt8), 1);
    chk("refill_tag0", 32'(tag8[0]), 5);
    chk("refill_tag1_zero", 32'(tag8[1]), 0);

    fv8 = 2'b01; ft8[0] = 3'd3; #1;
    chk("partial_gnt", 32'(gnt8), 1);
    tick();
    fv8 = 2'b00; req8 = 2'b01; #1;
    chk("partial_avail", 32'(avail8), 1);
    chk("partial_tag0", 32'(tag8[0]), 3);
    req8 = 2'b00; #1;

    fv8 = 2'b11; ft8[0] = 3'd0; ft8[1] = 3'd1; tick();
    chk("free01_avail", 32'(avail8), 3);
    ft8[0] = 3'd2; ft8[1] = 3'd4; tick();
    chk("free24_avail", 32'(avail8), 5);
    ft8[0] = 3'd5; ft8[1] = 3'd6; tick();
    chk("free56_avail", 32'(avail8), 7);
    ft8[0] = 3'd7; ft8[1] = 3'd7;
`ifdef STITCH_SB_TAG_POOL_CHECK_EN
    fv8 = 2'b01;
`endif
    tick();
    fv8 = 2'b00;
    chk("ovf_avail", 32'(avail8), 8);
    chk("ovf_full", 32'(full8), 1);
    chk("ovf_err", 32'(err8), 32'(OvfErr));
    tick();
    chk("ovf_err_sticky", 32'(err8), 32'(OvfErr));

    req8 = 2'b11; fv8 = 2'b11; ft8[0] = 3'd0; ft8[1] = 3'd1; flush8 = 1'b1; #1;
    chk("flush_gnt", 32'(gnt8), 3);
    tick();
    flush8 = 1'b0; fv8 = 2'b00; #1;
    chk("flush_avail", 32'(avail8), 8);
    chk("flush_tag0", 32'(tag8[0]), 0);
    chk("flush_tag1", 32'(tag8[1]), 1);
    chk("flush_err", 32'(err8), 0);

    tick();
    chk("pre_rst_avail", 32'(avail8), 6);
    req8 = 2'b00;
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_avail", 32'(avail8), 8);
    chk("async_rst_full", 32'(full8), 1);
    rst_ni = 1'b1;
    tick();

    // 6-tag wrap: pointers cross the non-power-of-two boundary several times.
    for (int i = 0; i < 6; i++) pool6.push_back(i);
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int c = 0; c < 3; c++) begin
        req6 = (c < 2) ? 2'b11 : 2'b01; #1;
        for (int k = 0; k < 2; k++) begin
          if (req6[k]) begin
            int exp_tag;
            exp_tag = pool6.pop_front();
            chk("wrap_gnt", 32'(gnt6[k]), 1);
            chk("wrap_tag", 32'(tag6[k]), exp_tag);
            outq.push_back(exp_tag);
          end
        end
        tick();
        req6 = 2'b00;
      end
      chk("wrap_avail_low", 32'(avail6), 1);
      for (int c = 0; c < 3; c++) begin
        int n;
        n = (c < 2) ? 2 : 1;
        for (int k = 0; k < n; k++) begin
          int t;
          t = outq.pop_back();
          ft6[k] = 3'(t);
          pool6.push_back(t);
        end
        fv6 = (n == 2) ? 2'b11 : 2'b01;
        tick();
        fv6 = 2'b00;
      end
      chk("wrap_avail_full", 32'(avail6), 6);
    end

    req6 = 2'b01; #1;
    chk("oor_pre_tag", 32'(tag6[0]), pool6[0]);
    tick();
    req6 = 2'b00;
    fv6 = 2'b01; ft6[0] = 3'd6; tick();
    fv6 = 2'b00;
    chk("oor_avail", 32'(avail6), 5);
    chk("oor_err", 32'(err6), 1);
    tick();
    chk("oor_err_sticky", 32'(err6), 1);
    chk("oor_err8_clean", 32'(err8), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
